// File: rtl/upcounter_pkg.sv
// Shared types and helpers for the up/down counter framer.
package upcounter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of whole bytes needed to carry a value of the given bit width.
  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/upcounter_core.sv
// Modulo up/down counter with clear and run/stop; range 0..MAX_COUNT.
module upcounter_core #(
  parameter  int MAX_COUNT = 9999,
  localparam int COUNT_W   = $clog2(MAX_COUNT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               i_runstop,
  input  logic               i_clear,
  input  logic               i_down,
  output logic [COUNT_W-1:0] o_count
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  // Clear wins over counting; counting wraps at both ends of the range.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_runstop && tick) begin
      if (i_down) begin
        o_count <= (o_count == '0) ? MAX_VAL : o_count - COUNT_W'(1);
      end else begin
        o_count <= (o_count == MAX_VAL) ? '0 : o_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/upcounter_framer.sv
// Counter plus snapshot framer: streams a frozen copy of the count as
// NUM_BYTES bytes over a valid/ready interface, so carries never tear a frame.
//
// state | meaning
// IDLE  | no frame on the wire; a request (or pending flag) starts one
// SEND  | presenting byte[idx]; advances on each valid & ready handshake
module upcounter_framer
  import upcounter_pkg::*;
#(
  parameter  int MAX_COUNT = 9999,
  parameter  int LSB_FIRST = 1,
  localparam int COUNT_W   = $clog2(MAX_COUNT + 1),
  localparam int NUM_BYTES = bytes_for(COUNT_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               i_runstop,
  input  logic               i_clear,
  input  logic               i_down,
  input  logic               i_snap,
  input  logic               i_tx_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [COUNT_W-1:0] o_count
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam int SNAP_W = NUM_BYTES * 8;

  state_t                      state, next_state;
  logic [NUM_BYTES-1:0][7:0]   snap_q;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            byte_sel;
  logic                        pending;
  logic                        handshake;
  logic                        frame_end;
  logic                        start;
  logic [COUNT_W-1:0]          count;

  upcounter_core #(.MAX_COUNT(MAX_COUNT)) u_core (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .i_runstop (i_runstop),
    .i_clear   (i_clear),
    .i_down    (i_down),
    .o_count   (count)
  );

  assign o_count  = count;
  assign o_busy   = (state == SEND) | pending;
  assign byte_sel = (LSB_FIRST != 0) ? idx : LAST_IDX - idx;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and handshake outputs; a request at the last handshake
  // restarts immediately so back-to-back frames have no bubble.
  always_comb begin
    next_state   = state;
    handshake    = 1'b0;
    frame_end    = 1'b0;
    start        = 1'b0;
    o_tx_valid   = 1'b0;
    o_frame_done = 1'b0;
    o_tx_data    = 8'h00;
    case (state)
      IDLE: begin
        if (i_snap || pending) begin
          start      = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = snap_q[byte_sel];
        handshake  = i_tx_ready;
        if (handshake && (idx == LAST_IDX)) begin
          frame_end    = 1'b1;
          o_frame_done = 1'b1;
          if (i_snap || pending) start = 1'b1;
          else                   next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Snapshot, byte index and the single merged pending request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_q  <= '0;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      if (start) begin
        snap_q <= SNAP_W'(count);
        idx    <= '0;
      end else if (handshake && !frame_end) begin
        idx <= idx + IDX_W'(1);
      end
      if (start)                          pending <= 1'b0;
      else if (i_snap && (state == SEND)) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upcounter_framer.sv
// Bench for upcounter_framer: three instances (LSB-first, MSB-first, 3-byte)
// share counter controls; each has its own snap/ready and expected-byte queue.
module tb_upcounter_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tick, i_runstop, i_clear, i_down;
  logic [2:0]  snap, ready;
  logic [7:0]  tx_data [3];
  logic [2:0]  tx_valid, busy, done;
  logic [13:0] count_a, count_b;
  logic [16:0] count_c;

  int checks = 0;
  int errors = 0;
  int model_cnt [3];
  int max_cnt [3] = '{9999, 9999, 99999};
  int nbytes  [3] = '{2, 2, 3};
  int lsb     [3] = '{1, 0, 1};
  logic [8:0] exp_q [3][$];

  upcounter_framer #(.MAX_COUNT(9999), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .tick(tick), .i_runstop(i_runstop),
    .i_clear(i_clear), .i_down(i_down), .i_snap(snap[0]), .i_tx_ready(ready[0]),
    .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]), .o_busy(busy[0]),
    .o_frame_done(done[0]), .o_count(count_a)
  );

  upcounter_framer #(.MAX_COUNT(9999), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .tick(tick), .i_runstop(i_runstop),
    .i_clear(i_clear), .i_down(i_down), .i_snap(snap[1]), .i_tx_ready(ready[1]),
    .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]), .o_busy(busy[1]),
    .o_frame_done(done[1]), .o_count(count_b)
  );

  upcounter_framer #(.MAX_COUNT(99999), .LSB_FIRST(1)) dut_big (
    .clk(clk), .reset(reset), .tick(tick), .i_runstop(i_runstop),
    .i_clear(i_clear), .i_down(i_down), .i_snap(snap[2]), .i_tx_ready(ready[2]),
    .o_tx_data(tx_data[2]), .o_tx_valid(tx_valid[2]), .o_busy(busy[2]),
    .o_frame_done(done[2]), .o_count(count_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int live_count(input int k);
    case (k)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  // Queue the bytes of a frame carrying value, in wire order for instance k.
  task automatic push_frame(input int k, input int value);
    for (int i = 0; i < nbytes[k]; i++) begin
      int b;
      logic [7:0] byt;
      logic lastb;
      b = (lsb[k] != 0) ? i : nbytes[k] - 1 - i;
      byt = 8'(value >> (8 * b));
      lastb = (i == nbytes[k] - 1);
      exp_q[k].push_back({lastb, byt});
    end
  endtask

  // Called at negedge+1 with this cycle's inputs set: check outputs,
  // advance the counter model through the coming edge, then wait.
  task automatic cycle();
    logic [8:0] e;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("count%0d", k), live_count(k), model_cnt[k]);
        if (tx_valid[k] && ready[k]) begin
          check($sformatf("byte_expected%0d", k), (exp_q[k].size() > 0), 1);
          if (exp_q[k].size() > 0) begin
            e = exp_q[k].pop_front();
            check($sformatf("tx_data%0d", k), tx_data[k], e[7:0]);
            check($sformatf("frame_done%0d", k), done[k], e[8]);
          end
        end else begin
          check($sformatf("done_idle%0d", k), done[k], 0);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        model_cnt[k] = 0;
        exp_q[k].delete();
      end else if (i_clear) begin
        model_cnt[k] = 0;
      end else if (i_runstop && tick) begin
        if (i_down) model_cnt[k] = (model_cnt[k] == 0) ? max_cnt[k] : model_cnt[k] - 1;
        else        model_cnt[k] = (model_cnt[k] == max_cnt[k]) ? 0 : model_cnt[k] + 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; i_runstop = 1'b1; i_clear = 1'b0; i_down = 1'b0;
    snap = 3'b000; ready = 3'b111;
    for (int k = 0; k < 3; k++) model_cnt[k] = 0;
    @(negedge clk); #1;
    run(2);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_valid", tx_valid[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_done", done[k], 0);
      check("rst_data", tx_data[k], 0);
      check("rst_count", live_count(k), 0);
    end

    // Wrap both ways and hold with run/stop low.
    i_down = 1'b1; tick = 1'b1;
    run(2);
    i_down = 1'b0;
    cycle(); check("up_to_max", count_a, 9999);
    cycle(); check("up_wrap", count_a, 0);
    i_down = 1'b1;
    cycle(); check("down_wrap", count_a, 9999);
    i_runstop = 1'b0;
    run(3); check("hold", count_a, 9999);
    i_runstop = 1'b1; tick = 1'b0; i_down = 1'b0;

    // Three-byte frame at 99999, then the next up-tick wraps to 0.
    check("big_at_max", count_c, 99999);
    snap[2] = 1'b1; push_frame(2, 99999);
    cycle();
    snap[2] = 1'b0; tick = 1'b1;
    cycle();
    tick = 1'b0;
    run(3);
    check("big_wrap", count_c, 0);
    check("big_idle", tx_valid[2], 0);

    // Reach 0x1234 and frame it both byte orders.
    i_clear = 1'b1; cycle(); i_clear = 1'b0;
    tick = 1'b1; run(4660); tick = 1'b0;
    check("count_1234", count_a, 4660);
    snap = 3'b011; push_frame(0, 4660); push_frame(1, 4660);
    cycle();
    snap = 3'b000;
    check("valid_lat_lsb", tx_valid[0], 1);
    check("valid_lat_msb", tx_valid[1], 1);
    cycle();
    check("valid_b1", tx_valid[0], 1);
    cycle();
    check("valid_drop_lsb", tx_valid[0], 0);
    check("valid_drop_msb", tx_valid[1], 0);
    check("busy_drop", busy[0], 0);

    // Backpressure on byte 0 while the counter keeps moving.
    ready[0] = 1'b0; tick = 1'b1;
    snap[0] = 1'b1; push_frame(0, 4660);
    cycle();
    snap[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", tx_data[0], 8'h34);
      check("bp_valid", tx_valid[0], 1);
      cycle();
    end
    ready[0] = 1'b1; tick = 1'b0;
    run(2);
    check("bp_done_idle", tx_valid[0], 0);

    // Two requests during one frame collapse into a single follow-on frame.
    i_clear = 1'b1; cycle(); i_clear = 1'b0;
    tick = 1'b1; run(100); tick = 1'b0;
    ready[0] = 1'b0;
    snap[0] = 1'b1; push_frame(0, 100);
    cycle();
    snap[0] = 1'b0; tick = 1'b1;
    run(5);
    check("count_105", count_a, 105);
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    cycle();
    tick = 1'b0;
    check("pending_busy", busy[0], 1);
    push_frame(0, 107);
    ready[0] = 1'b1;
    run(2);
    check("no_bubble", tx_valid[0], 1);
    run(2);
    check("merged_idle", tx_valid[0], 0);
    check("merged_busy", busy[0], 0);
    check("merged_drained", exp_q[0].size(), 0);

    // Clear mid-frame leaves the frame alone; reset mid-frame aborts it.
    ready[0] = 1'b0;
    snap[0] = 1'b1; push_frame(0, 107);
    cycle();
    snap[0] = 1'b0; i_clear = 1'b1; tick = 1'b1;
    cycle();
    i_clear = 1'b0; tick = 1'b0;
    check("clear_mid", count_a, 0);
    check("clear_keeps_data", tx_data[0], 8'd107);
    ready[0] = 1'b1;
    run(2);
    tick = 1'b1; run(3); tick = 1'b0;
    snap[0] = 1'b1; push_frame(0, 3);
    cycle();
    snap[0] = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("abort_valid", tx_valid[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_count", count_a, 0);
    run(2);

    for (int k = 0; k < 3; k++) check($sformatf("drained%0d", k), exp_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upcounter_framer.md
Name: upcounter_framer

Overview:
Parametrised successor of the SPI-side upcounter datapath. Counts ticks up or down, with run/stop and clear, over a configurable modulus. On request it snapshots the count and streams it as a coherent multi-byte frame over a valid/ready byte interface to the SPI master TX path. The snapshot means a carry between bytes can never tear the transmitted value.

Parameters:
MAX_COUNT, 9999, terminal count; counter range is 0..MAX_COUNT inclusive.
COUNT_W, $clog2(MAX_COUNT+1), counter width (derived; do not override).
NUM_BYTES, (COUNT_W+7)/8, bytes per frame (derived).
LSB_FIRST, 1, 1 = byte 0 carries count[7:0]; 0 = most-significant byte first.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  count enable strobe, one clk wide
i_runstop  in  1  1 = run, 0 = hold
i_clear  in  1  synchronous count clear
i_down  in  1  1 = count down, 0 = count up
i_snap  in  1  frame request strobe
i_tx_ready  in  1  downstream accepts o_tx_data this cycle
o_tx_data  out  8  current frame byte
o_tx_valid  out  1  o_tx_data is valid
o_busy  out  1  frame in progress or a request is pending
o_frame_done  out  1  one-cycle pulse on last-byte handshake
o_count  out  COUNT_W  live counter value

Behaviour:
- Reset: applied on a clk edge with reset==0. Clears the counter, snapshot, byte index and pending flag, and forces the FSM to IDLE. All outputs are 0 after reset. Reset applied mid-frame aborts the frame; o_tx_valid is 0 from the next edge.
- Counter priority: i_clear, then (i_runstop & tick), then hold.
  - Clear: count becomes 0 on the next edge, regardless of tick or direction.
  - Up: MAX_COUNT wraps to 0.
  - Down: 0 wraps to MAX_COUNT.
  - Values above MAX_COUNT are unreachable.
- Snapshot: taken from the registered count of the cycle in which i_snap is accepted. If tick arrives in the same cycle, the snapshot holds the pre-increment value. Bits above COUNT_W in the top byte are zero.
- FSM states: IDLE, SEND.
  - IDLE: i_snap (or a set pending flag) latches the snapshot, sets byte index to 0 and moves to SEND. o_tx_valid rises the cycle after i_snap (one-cycle latency).
  - SEND: o_tx_valid=1 and o_tx_data=byte[idx], selected by LSB_FIRST. Data is held stable while i_tx_ready=0.
  - A handshake (valid & ready) advances idx.
  - On the last byte's handshake: pulse o_frame_done, drop o_tx_valid on the next edge, go to IDLE. If a request is pending, go straight back to SEND with a new snapshot instead; o_tx_valid stays high and there is no bubble.
- i_snap while busy sets a single pending flag. Further requests while the flag is set are merged. The flag clears when its frame starts.
- i_clear during SEND does not alter the frame in flight. Only the live count clears.
- i_runstop=0 freezes the count but does not block framing.
- o_busy = (state==SEND) | pending.

Decomposition:
- Package upcounter_pkg: FSM state enum (IDLE, SEND) and a byte-count helper function bytes_for(width).
- Sub-module upcounter_core: the parametrised up/down modulo counter with clear and run/stop, output o_count.
- The top level holds the snapshot register, pending flag, byte index, mux and FSM.

Test Plan:
1. MAX_COUNT=9999: run up from 9998 with 2 ticks -> o_count 9999 then 0. Set i_down=1 at 0 with 1 tick -> 9999. i_runstop=0 with ticks -> count holds.
2. Count=4660 (0x1234), LSB_FIRST=1, i_tx_ready=1: i_snap -> 0x34 then 0x12 on consecutive cycles, o_frame_done with the second byte, o_tx_valid low afterwards. Repeat with LSB_FIRST=0 -> 0x12, 0x34.
3. Backpressure: hold i_tx_ready=0 for 5 cycles during byte 0 while ticks continue -> o_tx_data stays 0x34. After release, byte 1 is still 0x12.
4. i_snap pulsed twice during an active frame at counts 100 and 105 -> exactly one extra frame. It carries the count at the moment the first frame completes, with no idle cycle between frames.
5. i_clear and tick asserted together mid-frame -> o_count=0 next cycle; the in-flight frame still sends the original snapshot. Reset low mid-frame -> o_tx_valid=0, o_busy=0, o_count=0 next edge.
6. MAX_COUNT=99999 (NUM_BYTES=3): snap at 99999 (0x1869F) -> 0x9F, 0x86, 0x01; the next up-tick wraps to 0.
